// File: rtl/team11_add_arbiter.sv
// Round-robin two-requester arbiter feeding one registered WIDTH-bit adder.
// Latency: result valid one cycle after the operand transfer edge; one op per 3 cycles max.
// Backpressure: result held while res_ready=0; both req ready stay low until the result drains.
// Optional build macro TEAM11_ADD_SAT_EN saturates res_data to all ones on carry-out.
module team11_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_id,
    input  logic             res_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             prio_q;
    logic             id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             win0;
    logic             win1;
    logic             xfer;
    logic [WIDTH:0]   sum;

    // prio_q=1 means requester 1 wins a tie
    always_comb begin
        win0 = req0_valid && (!req1_valid || !prio_q);
        win1 = req1_valid && (!req0_valid || prio_q);
        sum  = {1'b0, a_q} + {1'b0, b_q};
    end

    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        xfer       = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready = win0;
                req1_ready = win1;
                xfer       = win0 || win1;
                if (xfer) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q    <= 1'b0;
            id_q      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_carry <= 1'b0;
            res_id    <= 1'b0;
        end else begin
            if (xfer) begin
                a_q    <= win1 ? req1_a : req0_a;
                b_q    <= win1 ? req1_b : req0_b;
                id_q   <= win1;
                prio_q <= !win1;
            end
            if (state_q == ADD) begin
`ifdef TEAM11_ADD_SAT_EN
                res_data <= sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
                res_data <= sum[WIDTH-1:0];
`endif
                res_carry <= sum[WIDTH];
                res_id    <= id_q;
                res_valid <= 1'b1;
            end else if (state_q == HOLD && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_team11_add_arbiter.sv
// Directed, table-driven bench for team11_add_arbiter plus hand sequences for
// backpressure and asynchronous reset in HOLD.
module tb_team11_add_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       res_valid, res_carry, res_id, res_ready, busy;
    logic [7:0] res_data;

    int checks = 0;
    int errors = 0;

`ifdef TEAM11_ADD_SAT_EN
    localparam logic [7:0] OVF_DATA = 8'hFF;
`else
    localparam logic [7:0] OVF_DATA = 8'h10;
`endif

    team11_add_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_data(res_data), .res_carry(res_carry), .res_id(res_id),
        .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // expected output packing: {req0_ready, req1_ready, res_valid, res_data, res_carry, res_id, busy}
    typedef struct packed {
        logic       v0;
        logic [7:0] a0;
        logic [7:0] b0;
        logic       v1;
        logic [7:0] a1;
        logic [7:0] b1;
        logic       rr;
        logic [13:0] exp;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                                input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                                input logic rr, input logic e0, input logic e1, input logic ev,
                                input logic [7:0] ed, input logic ec, input logic eid,
                                input logic eb);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.b0 = b0;
        v.v1 = v1; v.a1 = a1; v.b1 = b1;
        v.rr = rr;
        v.exp = {e0, e1, ev, ed, ec, eid, eb};
        return v;
    endfunction

    function automatic logic [13:0] outs();
        return {req0_ready, req1_ready, res_valid, res_data, res_carry, res_id, busy};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                         input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                         input logic rr);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        res_ready  = rr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // both valid: grants alternate 0,1,0,1
        for (int i = 0; i < 12; i++) begin
            case (i % 6)
                0: vecs[i] = mk(1, 8'h01, 8'h01, 1, 8'h02, 8'h02, 1, 1, 0, 0, (i == 0) ? 8'h00 : 8'h04, 0, (i == 0) ? 1'b0 : 1'b1, 0);
                1: vecs[i] = mk(1, 8'h01, 8'h01, 1, 8'h02, 8'h02, 1, 0, 0, 0, (i == 1) ? 8'h00 : 8'h04, 0, (i == 1) ? 1'b0 : 1'b1, 1);
                2: vecs[i] = mk(1, 8'h01, 8'h01, 1, 8'h02, 8'h02, 1, 0, 0, 1, 8'h02, 0, 0, 1);
                3: vecs[i] = mk(1, 8'h01, 8'h01, 1, 8'h02, 8'h02, 1, 0, 1, 0, 8'h02, 0, 0, 0);
                4: vecs[i] = mk(1, 8'h01, 8'h01, 1, 8'h02, 8'h02, 1, 0, 0, 0, 8'h02, 0, 0, 1);
                default: vecs[i] = mk(1, 8'h01, 8'h01, 1, 8'h02, 8'h02, 1, 0, 0, 1, 8'h04, 0, 1, 1);
            endcase
        end
        vecs[12] = mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h04, 0, 1, 0);
        // single requester 0: 12 + 34
        vecs[13] = mk(1, 8'h12, 8'h34, 0, 8'h00, 8'h00, 1, 1, 0, 0, 8'h04, 0, 1, 0);
        vecs[14] = mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h04, 0, 1, 1);
        vecs[15] = mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 1, 8'h46, 0, 0, 1);
        vecs[16] = mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h46, 0, 0, 0);
        // overflow through requester 1
        vecs[17] = mk(0, 8'h00, 8'h00, 1, 8'hF0, 8'h20, 1, 0, 1, 0, 8'h46, 0, 0, 0);
        vecs[18] = mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h46, 0, 0, 1);
        vecs[19] = mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 1, OVF_DATA, 1, 1, 1);
        vecs[20] = mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0, OVF_DATA, 1, 1, 0);
        // req0 pulse during ADD must be ignored
        vecs[21] = mk(1, 8'h05, 8'h06, 0, 8'h00, 8'h00, 1, 1, 0, 0, OVF_DATA, 1, 1, 0);
        vecs[22] = mk(1, 8'h70, 8'h01, 0, 8'h00, 8'h00, 1, 0, 0, 0, OVF_DATA, 1, 1, 1);
        vecs[23] = mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 1, 8'h0B, 0, 0, 1);
        vecs[24] = mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h0B, 0, 0, 0);
        vecs[25] = mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h0B, 0, 0, 0);

        rst_n = 1'b0;
        drive(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
        #3;
        chk("reset_outputs", 32'(outs()), 32'h0);
        step();
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].rr);
            #2;
            checks++;
            if (outs() !== vecs[i].exp) begin
                errors++;
                $display("FAIL vec%0d outs got %h expected %h", i, outs(), vecs[i].exp);
            end
            step();
        end

        // backpressure: hold the result 5 cycles while req1 waits
        drive(1, 8'h11, 8'h22, 0, 8'h00, 8'h00, 0);
        #2; chk("bp_req0_ready", 32'(req0_ready), 32'd1);
        step();
        drive(0, 8'h00, 8'h00, 1, 8'h03, 8'h04, 0);
        #2; chk("bp_add_req1_ready", 32'(req1_ready), 32'd0);
        step();
        for (int h = 0; h < 5; h++) begin
            #2;
            chk($sformatf("bp_hold%0d", h), {res_valid, res_data, res_carry, res_id, req1_ready, busy},
                {1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1});
            step();
        end
        res_ready = 1'b1;
        #2; chk("bp_release_valid", 32'(res_valid), 32'd1);
        step();
        #2; chk("bp_after_release", {res_valid, req1_ready, busy, res_data}, {1'b0, 1'b1, 1'b0, 8'h33});
        step();
        req1_valid = 1'b0;
        #2; chk("bp_req1_add", {req1_ready, busy}, {1'b0, 1'b1});
        step();
        #2; chk("bp_req1_result", {res_valid, res_data, res_carry, res_id}, {1'b1, 8'h07, 1'b0, 1'b1});
        step();

        // asynchronous reset while holding a req0 result
        drive(1, 8'h01, 8'h02, 0, 8'h00, 8'h00, 0);
        #2; chk("rst_seq_req0_ready", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        step();
        #2; chk("rst_seq_hold", {res_valid, res_data, res_id}, {1'b1, 8'h03, 1'b0});
        rst_n = 1'b0;
        #1; chk("rst_async_outputs", 32'(outs()), 32'h0);
        step();
        drive(1, 8'h08, 8'h08, 1, 8'h09, 8'h09, 0);
        rst_n = 1'b1;
        #2; chk("rst_prio_reset", {req0_ready, req1_ready}, {1'b1, 1'b0});
        step();
        drive(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
        step();
        #2; chk("rst_prio_result", {res_valid, res_data, res_id}, {1'b1, 8'h10, 1'b0});
        res_ready = 1'b1;
        step();
        #2; chk("final_idle", {res_valid, busy}, {1'b0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
